// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence presenter: state codes shown on the
// hex display and default timing values.
package exibe_sequencia_pkg;

    // State codes double as the db_estado value driven to the hex display.
    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        CARREGA = 4'h1,
        ESPERA  = 4'h2,
        ACESO   = 4'h3,
        APAGADO = 4'h4,
        FIM     = 4'hF
    } estado_t;

    localparam int TEMPO_ACESO_PADRAO   = 500;
    localparam int TEMPO_APAGADO_PADRAO = 250;
    localparam int ADDR_W_PADRAO        = 4;
    localparam int DATA_W_PADRAO        = 4;

endpackage

// File: rtl/exibe_sequencia_contador_tempo.sv
// Interval timer: counts while conta is high, clears on zera, and flags the
// last cycle of an M-cycle interval with fim.
module contador_tempo #(
    parameter int M = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    // A one-cycle interval still needs a one-bit register to exist.
    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] contagem;

    // Cycle counter; zera has priority so the owning state always starts from 0.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge value of its neighbours, whatever the statement order.
        if (reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta) begin
            contagem <= contagem + W'(1);
        end
    end

    assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence presenter for the memory game: walks memory positions 0..limite,
// lights each stored value on the LEDs for TEMPO_ACESO cycles followed by a
// mandatory TEMPO_APAGADO dark gap, then pulses pronto once.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int TEMPO_ACESO   = TEMPO_ACESO_PADRAO,
    parameter int TEMPO_APAGADO = TEMPO_APAGADO_PADRAO,
    parameter int ADDR_W        = ADDR_W_PADRAO,
    parameter int DATA_W        = DATA_W_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] limite,
    output logic [ADDR_W-1:0] endereco,
    input  logic [DATA_W-1:0] dado,
    output logic [DATA_W-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    estado_t           estado;
    estado_t           estado_prox;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] lim_reg;
    logic [DATA_W-1:0] leds_reg;
    logic              fim_aceso;
    logic              fim_apagado;

    // Each timer runs only inside its own state and is held at zero elsewhere,
    // so entering ACESO or APAGADO always starts a fresh interval.
    contador_tempo #(.M(TEMPO_ACESO)) u_tempo_aceso (
        .clock (clock),
        .reset (reset),
        .zera  (estado != ACESO),
        .conta (estado == ACESO),
        .fim   (fim_aceso)
    );

    contador_tempo #(.M(TEMPO_APAGADO)) u_tempo_apagado (
        .clock (clock),
        .reset (reset),
        .zera  (estado != APAGADO),
        .conta (estado == APAGADO),
        .fim   (fim_apagado)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state logic; abortar overrides everything once a run is under way.
    always_comb begin
        // NOTE: assigning the default first means every path drives
        // estado_prox, so no latch is inferred.
        estado_prox = estado;
        if (estado != INICIAL && abortar) begin
            estado_prox = INICIAL;
        end else begin
            case (estado)
                INICIAL: if (iniciar && !abortar) estado_prox = CARREGA;
                CARREGA: estado_prox = ESPERA;
                ESPERA:  estado_prox = ACESO;
                ACESO:   if (fim_aceso) estado_prox = APAGADO;
                APAGADO: if (fim_apagado) estado_prox = (idx == lim_reg) ? FIM : CARREGA;
                FIM:     estado_prox = INICIAL;
                default: estado_prox = INICIAL;
            endcase
        end
    end

    // Datapath: latch limite at start, step the address only when another
    // position follows (so idx never wraps), and capture the read word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            lim_reg  <= '0;
            leds_reg <= '0;
        end else begin
            if (estado == INICIAL && estado_prox == CARREGA) begin
                lim_reg <= limite;
                idx     <= '0;
            end
            if (estado == APAGADO && estado_prox == CARREGA) begin
                idx <= idx + ADDR_W'(1);
            end
            if (estado == ESPERA) begin
                leds_reg <= dado;
            end
        end
    end

    // Outputs are decoded from registers only.
    assign endereco  = idx;
    assign leds      = (estado == ACESO) ? leds_reg : '0;
    assign exibindo  = (estado != INICIAL);
    assign pronto    = (estado == FIM);
    assign db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: a synchronous memory model feeds the DUT, and a
// cycle-number reference computes every expected output from the position
// and offset inside the presentation.
module tb_exibe_sequencia;

    localparam int A = 4;
    localparam int D = 2;
    localparam int P = 2 + A + D;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic [3:0] limite;
    logic [3:0] endereco;
    logic [3:0] dado;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: run active, cycle number since start edge, latched limit,
    // address held while idle.
    bit m_active;
    int m_k;
    int m_lim;
    int m_idle_idx;

    exibe_sequencia #(
        .TEMPO_ACESO   (A),
        .TEMPO_APAGADO (D),
        .ADDR_W        (4),
        .DATA_W        (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .abortar   (abortar),
        .limite    (limite),
        .endereco  (endereco),
        .dado      (dado),
        .leds      (leds),
        .exibindo  (exibindo),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Synchronous read memory: data valid the cycle after the address.
    always @(posedge clock) dado <= mem[endereco];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, got, exp, $time, m_k);
        end
    endtask

    function automatic int fim_k();
        return (m_lim + 1) * P + 1;
    endfunction

    task automatic check_outputs();
        int e_leds, e_end, e_db, pos, off;
        bit e_ex, e_pr;
        if (m_active) begin
            e_ex = 1'b1;
            if (m_k == fim_k()) begin
                e_pr = 1'b1; e_leds = 0; e_end = m_lim; e_db = 15;
            end else begin
                pos = (m_k - 1) / P;
                off = (m_k - 1) % P;
                e_pr = 1'b0;
                e_end = pos;
                e_leds = (off >= 2 && off < 2 + A) ? int'(mem[pos]) : 0;
                e_db = (off == 0) ? 1 : (off == 1) ? 2 : (off < 2 + A) ? 3 : 4;
            end
        end else begin
            e_ex = 1'b0; e_pr = 1'b0; e_leds = 0; e_end = m_idle_idx; e_db = 0;
        end
        check("leds",      32'(leds),      32'(e_leds));
        check("exibindo",  32'(exibindo),  32'(e_ex));
        check("pronto",    32'(pronto),    32'(e_pr));
        check("endereco",  32'(endereco),  32'(e_end));
        check("db_estado", 32'(db_estado), 32'(e_db));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic step(input bit ini, input bit abo, input logic [3:0] lim_in);
        iniciar = ini;
        abortar = abo;
        limite  = lim_in;
        @(posedge clock);
        if (!m_active) begin
            if (ini && !abo) begin
                m_active = 1'b1;
                m_k      = 1;
                m_lim    = int'(lim_in);
            end
        end else if (abo) begin
            m_active   = 1'b0;
            m_idle_idx = (m_k == fim_k()) ? m_lim : (m_k - 1) / P;
        end else if (m_k == fim_k()) begin
            m_active   = 1'b0;
            m_idle_idx = m_lim;
        end else begin
            m_k++;
        end
        @(negedge clock);
        check_outputs();
    endtask

    // One presentation; optional abort at cycle abort_k, optional input noise
    // (stray iniciar pulses and limite changes) that must be ignored.
    task automatic run(input int lim, input int abort_k, input bit noise);
        int guard;
        bit ini, abo;
        logic [3:0] ln;
        guard = 0;
        step(1'b1, 1'b0, 4'(lim));
        while (m_active && guard < 200) begin
            abo = (abort_k > 0 && m_k == abort_k);
            ini = noise && ($urandom_range(3) == 0);
            ln  = noise ? 4'($urandom) : 4'(lim);
            step(ini, abo, ln);
            guard++;
        end
        check("run_ends", 32'(m_active), 32'(0));
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        mem = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                4'd3, 4'd0, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd15};
        reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; limite = 4'd0;
        m_active = 1'b0; m_k = 0; m_lim = 0; m_idle_idx = 0;

        @(negedge clock);
        @(negedge clock);
        check_outputs();
        reset = 1'b0;
        step(1'b0, 1'b0, 4'd0);

        // Single position, four-position walk, eight positions with repeated 1,1.
        run(0, 0, 1'b0);
        run(3, 0, 1'b0);
        run(7, 0, 1'b0);

        // Abort in the second lit interval, then restart from address 0.
        run(3, P + 4, 1'b0);
        run(2, 0, 1'b0);

        // iniciar together with abortar while idle: nothing starts.
        step(1'b1, 1'b1, 4'd5);
        step(1'b0, 1'b0, 4'd5);

        // Stray iniciar pulses and limite changes mid-run.
        run(5, 0, 1'b1);

        // Asynchronous reset between edges mid-run.
        step(1'b1, 1'b0, 4'd9);
        repeat (13) step(1'b0, 1'b0, 4'd9);
        #2 reset = 1'b1;
        #1;
        check("rst_leds",     32'(leds),     32'(0));
        check("rst_exibindo", 32'(exibindo), 32'(0));
        check("rst_pronto",   32'(pronto),   32'(0));
        check("rst_endereco", 32'(endereco), 32'(0));
        m_active = 1'b0; m_idle_idx = 0;
        @(negedge clock);
        check_outputs();
        reset = 1'b0;
        step(1'b0, 1'b0, 4'd0);

        // Full-range walk: sixteen values, no address wrap.
        run(15, 0, 1'b0);

        // Randomized runs with noise and occasional aborts.
        repeat (8) begin
            run(int'($urandom_range(15)),
                ($urandom_range(3) == 0) ? int'($urandom_range(1, 60)) : 0,
                1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
